mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: ysyx_23060180_mem_arbiter

Interface
REQ-001 SHALL provide parameter: RD_LATENCY, default 1, memory read latency in cycles, legal range 1..7.
REQ-002 SHALL provide ports:
- clk  input  1  clock, all state on rising edge
- rstn_in  input  1  reset, asynchronous, active-low
- ifu_req  input  1  fetch read request, held until granted
- ifu_addr  input  32  fetch address
- ifu_gnt  output  1  fetch request accepted this cycle
- ifu_rvalid  output  1  fetch read data valid
- ifu_rdata  output  32  fetch read data
- lsu_req  input  1  load/store request, held until granted
- lsu_we  input  1  1=store, 0=load
- lsu_addr  input  32  load/store address
- lsu_wdata  input  32  store data
- lsu_wmask  input  4  store byte-size code, passed through unchanged
- lsu_gnt  output  1  load/store request accepted this cycle
- lsu_rvalid  output  1  load data valid
- lsu_rdata  output  32  load data
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_wmask  output  4  memory write byte-size code
- mem_rdata  input  32  memory read data, valid RD_LATENCY cycles after mem_rd
- busy  output  1  read outstanding (state WAIT)

Function
REQ-003 SHALL implement two states: IDLE, WAIT.
REQ-004 In IDLE, arbitration SHALL be combinational over ifu_req and lsu_req; exactly one gnt, never both.
REQ-005 Single requester in IDLE SHALL be granted in the same cycle.
REQ-006 Both requesting in IDLE SHALL grant the requester not granted last (round-robin pointer); pointer updated on every grant.
REQ-007 In the grant cycle the winner's command SHALL drive the memory port combinationally: mem_addr=winner addr; mem_rd=1 for IFU or LSU load; mem_wr=1, mem_wdata=lsu_wdata, mem_wmask=lsu_wmask for LSU store.
REQ-008 Outside a grant cycle mem_rd, mem_wr SHALL be 0 and mem_addr, mem_wdata, mem_wmask SHALL be 0.
REQ-009 A granted store SHALL complete in the grant cycle; state stays IDLE; no rvalid generated; next grant possible next cycle.
REQ-010 A granted read SHALL move IDLE->WAIT, load a 3-bit down-counter with RD_LATENCY, and record the owner (IFU/LSU).
REQ-011 In WAIT, counter SHALL decrement each cycle; when the counter reaches 0 (RD_LATENCY cycles after mem_rd), owner rvalid=1 for exactly one cycle with owner rdata=mem_rdata, and state SHALL return to IDLE on the next edge.
REQ-012 No grant SHALL be issued in WAIT, including the rvalid cycle; requests wait without being dropped.
REQ-013 rdata outputs SHALL be 0 whenever the matching rvalid is 0.
REQ-014 busy SHALL equal (state==WAIT).
REQ-015 Requester deasserting req before gnt SHALL be treated as withdrawn; no side effects.
REQ-016 Address/data SHALL be sampled only in the grant cycle; changes afterwards SHALL have no effect.

Reset
REQ-017 rstn_in low SHALL asynchronously force state=IDLE, counter=0, owner=IFU, round-robin pointer=IFU (LSU wins first tie), and all outputs 0.
REQ-018 Reset during WAIT SHALL abandon the outstanding read; no rvalid after reset release.
REQ-019 First grant SHALL be possible in the first cycle after rstn_in deasserts.

Verification
REQ-020 RD_LATENCY=1, ifu_req, ifu_addr=0x80000000 -> ifu_gnt and mem_rd same cycle, mem_addr=0x80000000; next cycle ifu_rvalid=1, ifu_rdata=mem_rdata (e.g. 0x00100073); busy=1 for 1 cycle.
REQ-021 After reset both req in same cycle -> lsu_gnt first; after LSU read completes, ifu_gnt; with both held continuously grants alternate LSU, IFU, LSU.
REQ-022 lsu_we=1, lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF, lsu_wmask=4 -> mem_wr=1 with those values for one cycle, no lsu_rvalid, busy stays 0, pending ifu_req granted next cycle.
REQ-023 RD_LATENCY=3, LSU load granted, ifu_req raised during WAIT -> no ifu_gnt for 3 cycles; lsu_rvalid exactly 3 cycles after mem_rd; ifu_gnt the cycle after.
REQ-024 rstn_in pulsed low mid-WAIT -> outputs 0 immediately, no rvalid afterwards, next ifu_req granted in first post-reset cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between the instruction fetch unit (IFU)
// and the load/store unit (LSU). One command is issued per grant. Stores
// finish in their grant cycle. A read parks the arbiter in WAIT until its
// data returns RD_LATENCY cycles later. When both units request at once,
// a round-robin pointer chooses between them.
//
// Parameters
//   RD_LATENCY  memory read latency in cycles (1..7)
//
// Ports
//   clk, rstn_in                 clock (rising edge), async active-low reset
//   ifu_req/addr                 fetch read request, held until ifu_gnt
//   ifu_gnt/rvalid/rdata         fetch accept strobe and read return
//   lsu_req/we/addr/wdata/wmask  load/store request, held until lsu_gnt
//   lsu_gnt/rvalid/rdata         load/store accept strobe and load return
//   mem_rd/wr/addr/wdata/wmask   memory command, driven only in a grant cycle
//   mem_rdata                    memory read data, RD_LATENCY cycles after mem_rd
//   busy                         a read is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn_in,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,

    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    // state | meaning
    // IDLE  | arbitrate; a winner's command goes to memory this cycle
    // WAIT  | read outstanding; counting down to the data return, no grants
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic       OWN_IFU = 1'b0;
    localparam logic       OWN_LSU = 1'b1;
    localparam logic [2:0] LAT     = 3'(RD_LATENCY);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       rr_last;      // requester granted most recently

    logic       can_grant;
    logic       grant_ifu;
    logic       grant_lsu;
    logic       grant_rd;
    logic       rd_done;

    // Grants are combinational from the requests, so they must also be
    // gated by reset. That keeps every output at 0 while rstn_in is low.
    assign can_grant = rstn_in && (state == IDLE);

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (can_grant) begin
            if (ifu_req && lsu_req) begin
                if (rr_last == OWN_IFU) begin
                    grant_lsu = 1'b1;
                end else begin
                    grant_ifu = 1'b1;
                end
            end else if (ifu_req) begin
                grant_ifu = 1'b1;
            end else if (lsu_req) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign ifu_gnt  = grant_ifu;
    assign lsu_gnt  = grant_lsu;
    assign grant_rd = grant_ifu || (grant_lsu && !lsu_we);

    // The memory port carries only the winner's command. Everything else
    // stays at 0, so nothing from a losing or withdrawn request leaks out.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (grant_ifu) begin
            mem_rd   = 1'b1;
            mem_addr = ifu_addr;
        end else if (grant_lsu) begin
            mem_addr = lsu_addr;
            if (lsu_we) begin
                mem_wr    = 1'b1;
                mem_wdata = lsu_wdata;
                mem_wmask = lsu_wmask;
            end else begin
                mem_rd = 1'b1;
            end
        end
    end

    // The counter is loaded with RD_LATENCY at the grant. It reaches 0 on
    // the edge that ends the data-return cycle, so the return cycle is the
    // one where the counter still holds 1. A stray 0 also ends the wait,
    // which keeps the FSM from stalling in WAIT.
    assign rd_done = rstn_in && (state == WAIT) && (cnt <= 3'd1);

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            owner   <= OWN_IFU;
            rr_last <= OWN_IFU;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        rr_last <= grant_lsu ? OWN_LSU : OWN_IFU;
                    end
                    if (grant_rd) begin
                        state <= WAIT;
                        cnt   <= LAT;
                        owner <= grant_lsu ? OWN_LSU : OWN_IFU;
                    end
                end
                WAIT: begin
                    if (rd_done) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign ifu_rvalid = rd_done && (owner == OWN_IFU);
    assign lsu_rvalid = rd_done && (owner == OWN_LSU);
    assign ifu_rdata  = ifu_rvalid ? mem_rdata : 32'h0;
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : 32'h0;
    assign busy       = (state == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters share this bench: instance 0 with RD_LATENCY=1 and
// instance 1 with RD_LATENCY=3. Each has its own small memory model, which
// returns a pattern derived from the read address after the latency.
// Expected read returns are queued when a read is granted and are checked
// when an rvalid appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       rstn;
    logic [1:0]       ifu_req, lsu_req, lsu_we;
    logic [1:0][31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [1:0][3:0]  lsu_wmask;
    logic [1:0]       ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_rd, mem_wr, busy;
    logic [1:0][31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [1:0][3:0]  mem_wmask;

    typedef struct {
        int          d;
        bit          own_lsu;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0010_0073 : {a[15:0], ~a[15:0]};
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] all_out(input int d);
        return ifu_rdata[d] | lsu_rdata[d] | mem_addr[d] | mem_wdata[d] |
               32'({ifu_gnt[d], ifu_rvalid[d], lsu_gnt[d], lsu_rvalid[d],
                    mem_rd[d], mem_wr[d], busy[d], mem_wmask[d]});
    endfunction

    task automatic mon(input int d);
        exp_t e;
        chk("gnt_excl", 32'(ifu_gnt[d] & lsu_gnt[d]), 32'h0);
        if (!ifu_gnt[d] && !lsu_gnt[d])
            chk("mem_idle", mem_addr[d] | mem_wdata[d] |
                32'({mem_rd[d], mem_wr[d], mem_wmask[d]}), 32'h0);
        if (!ifu_rvalid[d]) chk("ifu_rdata_zero", ifu_rdata[d], 32'h0);
        if (!lsu_rvalid[d]) chk("lsu_rdata_zero", lsu_rdata[d], 32'h0);
        if (ifu_rvalid[d] || lsu_rvalid[d]) begin
            if (sb.size() == 0 || sb[0].d != d) begin
                chk("rv_unexpected", 32'({ifu_rvalid[d], lsu_rvalid[d]}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rv_cycle", 32'(cyc), 32'(e.due));
                chk("rv_owner", 32'({lsu_rvalid[d], ifu_rvalid[d]}), e.own_lsu ? 32'd2 : 32'd1);
                chk("rv_data", e.own_lsu ? lsu_rdata[d] : ifu_rdata[d], e.data);
            end
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pipe_d [LAT] = '{default: 32'h0};
        logic        pipe_v [LAT] = '{default: 1'b0};
        logic [31:0] mrd;

        mem_arbiter #(.RD_LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rstn_in    (rstn[g]),
            .ifu_req    (ifu_req[g]),
            .ifu_addr   (ifu_addr[g]),
            .ifu_gnt    (ifu_gnt[g]),
            .ifu_rvalid (ifu_rvalid[g]),
            .ifu_rdata  (ifu_rdata[g]),
            .lsu_req    (lsu_req[g]),
            .lsu_we     (lsu_we[g]),
            .lsu_addr   (lsu_addr[g]),
            .lsu_wdata  (lsu_wdata[g]),
            .lsu_wmask  (lsu_wmask[g]),
            .lsu_gnt    (lsu_gnt[g]),
            .lsu_rvalid (lsu_rvalid[g]),
            .lsu_rdata  (lsu_rdata[g]),
            .mem_rd     (mem_rd[g]),
            .mem_wr     (mem_wr[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wmask  (mem_wmask[g]),
            .mem_rdata  (mrd),
            .busy       (busy[g])
        );

        always @(posedge clk) begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            pipe_v[0] <= mem_rd[g];
            pipe_d[0] <= mem_model(mem_addr[g]);
        end

        assign mrd = pipe_v[LAT-1] ? pipe_d[LAT-1] : (32'hA5A5_0000 | 32'(cyc & 16'hFFFF));

        always @(negedge clk) if (rstn[g]) mon(g);
    end

    // Called at posedge+1. Raises a request, waits for its grant, checks
    // the memory command, queues any read return, and drops the request
    // one cycle after the grant while corrupting its address and data.
    task automatic do_req(input int d, input bit lsu, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, output int gcyc);
        int k = 0;
        bit got = 0;
        bit st;
        exp_t e;
        st = lsu && we;
        if (lsu) begin
            lsu_req[d] = 1'b1; lsu_we[d] = we; lsu_addr[d] = addr;
            lsu_wdata[d] = wdata; lsu_wmask[d] = wmask;
        end else begin
            ifu_req[d] = 1'b1; ifu_addr[d] = addr;
        end
        gcyc = -1;
        while (!got && k < 100) begin
            @(negedge clk);
            if (lsu ? lsu_gnt[d] : ifu_gnt[d]) got = 1;
            else begin @(posedge clk); #1; k++; end
        end
        if (!got) begin
            chk("gnt_timeout", 32'h0, 32'h1);
        end else begin
            gcyc = cyc;
            chk("mem_rd", 32'(mem_rd[d]), 32'(!st));
            chk("mem_wr", 32'(mem_wr[d]), 32'(st));
            chk("mem_addr", mem_addr[d], addr);
            chk("mem_wdata", mem_wdata[d], st ? wdata : 32'h0);
            chk("mem_wmask", 32'(mem_wmask[d]), st ? 32'(wmask) : 32'h0);
            chk("busy_at_gnt", 32'(busy[d]), 32'h0);
            if (!st) begin
                e.d = d; e.own_lsu = lsu; e.data = mem_model(addr); e.due = gcyc + lat(d);
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        if (lsu) begin
            lsu_req[d] = 1'b0; lsu_addr[d] = ~addr; lsu_wdata[d] = ~wdata; lsu_we[d] = ~we;
        end else begin
            ifu_req[d] = 1'b0; ifu_addr[d] = ~addr;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_busy(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); chk("busy_wait", 32'(busy[d]), 32'h1);
        end
        @(negedge clk); chk("busy_done", 32'(busy[d]), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int g1, g2, g3, rel;
        rstn = '0; ifu_req = '1; lsu_req = '1; lsu_we = '0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        idle(3);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("rst_outputs", all_out(d), 32'h0);
        @(posedge clk); #1;
        ifu_req = '0; lsu_req = '0;
        rstn = '1;
        rel = cyc;

        // Single fetch at latency 1, granted in the first cycle after reset.
        do_req(0, 0, 0, 32'h8000_0000, 0, 0, g1);
        chk("first_gnt_cycle", 32'(g1), 32'(rel));
        chk_busy(0, 1);
        idle(2);

        // Tie after reset: LSU first, then alternating while both keep requesting.
        rstn[0] = 1'b0; idle(1); rstn[0] = 1'b1;
        fork
            begin
                do_req(0, 1, 0, 32'h8000_0100, 0, 0, g1);
                do_req(0, 1, 0, 32'h8000_0200, 0, 0, g3);
            end
            do_req(0, 0, 0, 32'h8000_0004, 0, 0, g2);
        join
        chk("rr_ifu_after_lsu", 32'(g2 - g1), 32'd2);
        chk("rr_lsu_after_ifu", 32'(g3 - g2), 32'd2);
        idle(3);

        // Store wins the tie (pointer at IFU); the pending fetch goes next cycle.
        do_req(0, 0, 0, 32'h8000_0008, 0, 0, g1);
        fork
            do_req(0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'd4, g1);
            do_req(0, 0, 0, 32'h8000_000C, 0, 0, g2);
        join
        chk("store_then_fetch", 32'(g2 - g1), 32'd1);
        idle(3);

        // Latency 3: a fetch raised during WAIT is held off until after rvalid.
        do_req(1, 1, 0, 32'h8000_2000, 0, 0, g1);
        do_req(1, 0, 0, 32'h8000_0010, 0, 0, g2);
        chk("wait_blocks_gnt", 32'(g2 - g1), 32'd4);
        idle(4);

        // A fetch request withdrawn during WAIT must never be granted.
        do_req(1, 1, 0, 32'h8000_2004, 0, 0, g1);
        ifu_req[1] = 1'b1; ifu_addr[1] = 32'h8000_0014;
        idle(1);
        ifu_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk("withdrawn_no_gnt", 32'(ifu_gnt[1]), 32'h0);
        end
        idle(1);

        // Reset pulse in the middle of WAIT.
        do_req(1, 1, 0, 32'h8000_2008, 0, 0, g1);
        ifu_req[1] = 1'b1; ifu_addr[1] = 32'h8000_0020;
        #2 rstn[1] = 1'b0;
        #1 chk("rst_mid_wait_outputs", all_out(1), 32'h0);
        sb.delete();
        @(posedge clk); #2;
        rstn[1] = 1'b1;
        rel = cyc;
        do_req(1, 0, 0, 32'h8000_0020, 0, 0, g2);
        chk("post_rst_first_gnt", 32'(g2), 32'(rel));
        idle(6);

        // Random mixed traffic at latency 3.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, w;
            bit l, s;
            l = 1'($urandom_range(0, 1));
            s = l && 1'($urandom_range(0, 1));
            a = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
            w = $urandom;
            do_req(1, l, s, a, w, 4'($urandom_range(0, 15)), g1);
            idle($urandom_range(0, 2));
        end
        idle(8);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
